// File: rtl/brcomp_iter.sv
// brcomp_iter: iterative MSB-first chunked branch comparator with funct3 decode.
module brcomp_iter #(
    parameter int XLEN  = 32,
    parameter int CHUNK = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    input  logic [2:0]      i_funct3,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic            o_br_equal,
    output logic            o_br_less,
    output logic            o_br_taken,
    output logic            o_br_illegal
);
    localparam int NCHUNK = XLEN / CHUNK;
    localparam int KW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
    localparam logic [CHUNK-1:0] MSK = CHUNK'(1) << (CHUNK - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]      f_q, f_d;
    logic            eq_q, eq_d, lt_q, lt_d, tk_q, tk_d, il_q, il_d;
    logic [CHUNK-1:0] ca, cb;
    logic            sgn, last;

    // Only the unsigned-compare modes skip the MSB flip; illegal funct3 compares signed.
    assign sgn  = (k_q == '0) && !(f_q[2] && f_q[1]);
    assign ca   = CHUNK'(a_q >> (XLEN - CHUNK - k_q * CHUNK)) ^ (sgn ? MSK : '0);
    assign cb   = CHUNK'(b_q >> (XLEN - CHUNK - k_q * CHUNK)) ^ (sgn ? MSK : '0);
    assign last = k_q == KW'(NCHUNK - 1);

    assign o_ready      = (state_q == IDLE) && !i_rst;
    assign o_valid      = state_q == DONE;
    assign o_br_equal   = eq_q;
    assign o_br_less    = lt_q;
    assign o_br_taken   = tk_q;
    assign o_br_illegal = il_q;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        f_d     = f_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        tk_d    = tk_q;
        il_d    = il_q;
        case (state_q)
            IDLE: if (i_valid && !i_flush) begin
                state_d = BUSY;
                k_d     = '0;
                a_d     = i_rs1_data;
                b_d     = i_rs2_data;
                f_d     = i_funct3;
            end
            BUSY: if (i_flush) begin
                state_d = IDLE;
            end else if (ca != cb || last) begin
                state_d = DONE;
                eq_d    = ca == cb;
                lt_d    = ca < cb;
                tk_d    = f_q[2] ? (lt_d ^ f_q[0]) : (!f_q[1] && (eq_d ^ f_q[0]));
                il_d    = !f_q[2] && f_q[1];
            end else begin
                k_d = k_q + 1'b1;
            end
            DONE: state_d = (i_flush || i_ready) ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            f_q     <= '0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            tk_q    <= 1'b0;
            il_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            f_q     <= f_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
            tk_q    <= tk_d;
            il_q    <= il_d;
        end
    end
endmodule

// File: tb/tb_brcomp_iter.sv
// tb_brcomp_iter: four comparators (CHUNK 8/1/4/32) driven in lockstep against a reference model.
module tb_brcomp_iter;
    localparam int CH [4] = '{8, 1, 4, 32};

    logic        i_clk, i_rst, i_valid, i_flush, i_ready;
    logic [31:0] i_rs1_data, i_rs2_data;
    logic [2:0]  i_funct3;
    logic [3:0]  rdy, ov, eq, lt, tk, il;
    int          nvec = 0, nerr = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        brcomp_iter #(.XLEN(32), .CHUNK(g == 0 ? 8 : g == 1 ? 1 : g == 2 ? 4 : 32)) u_dut (
            .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(rdy[g]),
            .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_funct3(i_funct3),
            .i_flush(i_flush), .o_valid(ov[g]), .i_ready(i_ready),
            .o_br_equal(eq[g]), .o_br_less(lt[g]), .o_br_taken(tk[g]), .o_br_illegal(il[g])
        );
    end

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Latency = index of first differing chunk from the top, plus one; NCHUNK if all equal.
    function automatic int mlat(input logic [31:0] a, input logic [31:0] b, input int c);
        for (int j = 0; j < 32 / c; j++)
            if (((a ^ b) >> (32 - (j + 1) * c)) != 0) return j + 1;
        return 32 / c;
    endfunction

    function automatic logic [3:0] mres(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
        logic e, l, t;
        e = a == b;
        l = (f == 3'b110 || f == 3'b111) ? (a < b) : ($signed(a) < $signed(b));
        case (f)
            3'b000: t = e;
            3'b001: t = !e;
            3'b100, 3'b110: t = l;
            3'b101, 3'b111: t = !l;
            default: t = 1'b0;
        endcase
        return {e, l, t, f == 3'b010 || f == 3'b011};
    endfunction

    task automatic start(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
        @(negedge i_clk);
        chk("ready_idle", 32'(rdy), 32'hF);
        i_rs1_data = a;
        i_rs2_data = b;
        i_funct3   = f;
        i_valid    = 1'b1;
        @(negedge i_clk);
        i_valid    = 1'b0;
        i_rs1_data = $urandom;
        i_rs2_data = $urandom;
        i_funct3   = 3'($urandom);
        chk("accepted", 32'(rdy), 32'h0);
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f, input int hold);
        int lat [4];
        logic [3:0] r;
        logic [15:0] snap;
        lat = '{0, 0, 0, 0};
        start(a, b, f);
        for (int c = 1; c <= 40 && ov != 4'hF; c++) begin
            @(negedge i_clk);
            for (int d = 0; d < 4; d++) if (ov[d] && lat[d] == 0) lat[d] = c;
        end
        r = mres(a, b, f);
        for (int d = 0; d < 4; d++) chk($sformatf("latency_c%0d", CH[d]), 32'(lat[d]), 32'(mlat(a, b, CH[d])));
        chk("equal", 32'(eq), {28'h0, {4{r[3]}}});
        chk("less", 32'(lt), {28'h0, {4{r[2]}}});
        chk("taken", 32'(tk), {28'h0, {4{r[1]}}});
        chk("illegal", 32'(il), {28'h0, {4{r[0]}}});
        chk("ready_done", 32'(rdy), 32'h0);
        snap = {eq, lt, tk, il};
        repeat (hold) begin
            @(negedge i_clk);
            chk("hold_valid", 32'(ov), 32'hF);
            chk("hold_result", 32'({eq, lt, tk, il}), 32'(snap));
            chk("hold_ready", 32'(rdy), 32'h0);
        end
        i_ready = 1'b1;
        @(negedge i_clk);
        i_ready = 1'b0;
        chk("consumed_valid", 32'(ov), 32'h0);
        chk("consumed_ready", 32'(rdy), 32'hF);
    endtask

    initial begin
        logic [31:0] a, b;
        i_rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b0;
        i_rs1_data = '0; i_rs2_data = '0; i_funct3 = '0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        chk("reset_outputs", 32'({ov, eq, lt, tk, il}), 32'h0);
        chk("reset_ready", 32'(rdy), 32'h0);
        i_rst = 1'b0;
        #1 chk("ready_after_release", 32'(rdy), 32'hF);

        run(32'h1234_5678, 32'h1234_5678, 3'b000, 0);
        run(32'h1234_5678, 32'h1234_5678, 3'b001, 0);
        run(32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 0);
        run(32'hFFFF_FFFF, 32'h0000_0001, 3'b110, 0);
        run(32'd5, 32'd7, 3'b101, 3);

        start(32'd5, 32'd7, 3'b101);
        @(negedge i_clk);
        i_flush = 1'b1;
        @(negedge i_clk);
        i_flush = 1'b0;
        chk("flush_valid", 32'(ov), 32'h0);
        chk("flush_ready", 32'(rdy), 32'hF);
        repeat (4) begin
            @(negedge i_clk);
            chk("flush_no_valid", 32'(ov), 32'h0);
        end
        run(32'd9, 32'd9, 3'b000, 0);

        start(32'd5, 32'd7, 3'b101);
        repeat (2) @(negedge i_clk);
        i_rst = 1'b1;
        #1;
        chk("midrun_reset_outputs", 32'({ov, eq, lt, tk, il}), 32'h0);
        chk("midrun_reset_ready", 32'(rdy), 32'h0);
        @(negedge i_clk);
        i_rst = 1'b0;
        #1 chk("ready_after_midrun_reset", 32'(rdy), 32'hF);
        run(32'h8000_0000, 32'h7FFF_FFFF, 3'b100, 0);

        run(32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'b010, 0);
        run(32'h0000_0003, 32'h8000_0003, 3'b011, 0);

        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = a ^ (32'h1 << $urandom_range(0, 31));
                default: b = $urandom;
            endcase
            run(a, b, 3'($urandom), $urandom_range(0, 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
